banco_limites_temperatura: RTL
==============================

# banco_limites_temperatura

Programmable bank of the seven temperature thresholds consumed by the level comparator. The controller writes new values into shadow registers through a valid/ready port, then issues a commit. A sequential checker verifies strict ascending order one pair per cycle, and only then copies all seven values atomically into the active outputs `lim_temp1..lim_temp7`. The level comparator therefore never sees a partially updated or inconsistent threshold set.

## Interface
- `DEF_BASE`, default 16'd400: reset value of `lim_temp1` (unsigned 16-bit sensor units).
- `DEF_STEP`, default 16'd50: reset spacing between thresholds; threshold k (0-based) resets to `DEF_BASE + k*DEF_STEP`, computed modulo 2^16.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write can be accepted; high only in IDLE.
- `wr_idx`  in  3  shadow index 0..6; index 7 is accepted and discarded.
- `wr_data`  in  16  threshold value, unsigned.
- `commit`  in  1  request verify-and-apply; sampled only in IDLE.
- `busy`  out  1  high when the FSM is not in IDLE.
- `commit_done`  out  1  one-cycle pulse; new thresholds are visible in the same cycle.
- `commit_err`  out  1  one-cycle pulse; order check failed and the active set is unchanged.
- `err_idx`  out  3  lower index of the first failing pair; held until the next commit is accepted.
- `lim_temp1..lim_temp7`  out  16 each  active thresholds.

## Operation
- Storage: `shadow[0..6]` and `active[0..6]` are registers. `lim_temp(k+1) = active[k]`.
- Write: a write is accepted on any edge where `wr_valid && wr_ready`, and `shadow[wr_idx] <= wr_data`. The port has no backpressure other than `wr_ready`.
- FSM states: IDLE, VERIFY, APPLY.
- IDLE -> VERIFY when `commit` is high. The counter `i` is cleared to 0 and `err_idx` is cleared to 0.
- VERIFY: compare `shadow[i] < shadow[i+1]` (unsigned, strict). Equal values fail.
  - Pass and `i == 5`: go to APPLY.
  - Pass and `i < 5`: increment `i`.
  - Fail: `err_idx <= i`, pulse `commit_err` on the next cycle, return to IDLE.
- APPLY: `active[k] <= shadow[k]` for all k on one edge, pulse `commit_done` on the next cycle, return to IDLE.
- Simultaneous `wr_valid` and `commit` in IDLE: the write is accepted and the commit starts on the same edge. Verification sees the new value.
- `commit` while busy: ignored, not queued.
- Reset (asynchronous, any time including mid-VERIFY or APPLY):
  - shadow and active both return to the defaults; FSM returns to IDLE.
  - `commit_done = 0`, `commit_err = 0`, `err_idx = 0`, `busy = 0`.
  - `wr_ready = 1` after reset deasserts.
- Default set must itself be strictly ascending. `DEF_STEP` = 0 or wrap-around makes the first commit of unchanged defaults fail; that is legal but flagged in the integration notes.

## Timing
- Commit sampled at edge E0.
- VERIFY occupies cycles 1..6, APPLY occupies cycle 7.
- Active outputs update at edge E8, and `commit_done` is high during cycle 8. Total latency is 8 cycles.
- Failure at pair i: `commit_err` is high in cycle i+2 and `wr_ready` returns in the same cycle.
- `busy` is high in cycles 1..7 (success) or 1..i+1 (failure).
- All outputs are registered; no combinational path from inputs to outputs except `wr_ready` and `busy`, which are decoded from the state register.

## Configuration
- Macro: `BANCO_LIMITES_ORDER_CHECK_EN`.
- Defined: full VERIFY sequence as above.
- Undefined:
  - VERIFY is removed; IDLE -> APPLY directly and `commit_done` is high in cycle 2.
  - `commit_err` is tied 0 and `err_idx` is tied 0.
  - No comparator is instantiated.

## Structure
- Shared include/package `limites_temperatura_pkg`:
  - state encodings (IDLE = 2'd0, VERIFY = 2'd1, APPLY = 2'd2);
  - `NUM_LIM = 7`;
  - `IDX_W = 3`;
  - `TEMP_W = 16`.
- One sub-module: the existing `comparador_n` (N = 16), instantiated once.
  - A = `shadow[i]`, B = `shadow[i+1]`; the check uses its `lt` output.

## Test plan
- Reset, then read outputs -> `lim_temp1..7` = 400, 450, 500, 550, 600, 650, 700; `busy` = 0; `wr_ready` = 1.
- Write shadow = 100, 200, 300, 400, 500, 600, 700, then commit -> outputs unchanged through cycle 7; new set visible with `commit_done` = 1 in cycle 8.
- Write `shadow[3]` = 250 (below `shadow[2]` = 300), then commit -> `commit_err` pulses in cycle 4; `err_idx` = 2; active set unchanged.
- Write `shadow[4]` = `shadow[5]` = 600, then commit -> fails with `err_idx` = 4. Also issue commit and `wr_valid` during `busy` -> both ignored and `wr_ready` = 0.
- Write `wr_idx` = 7 with data 0xFFFF together with commit -> the write is dropped and the commit succeeds. Separately, pulse `reset_n` low in cycle 4 of a commit -> defaults restored, no done or err pulse.

Source files
------------

// File: rtl/limites_temperatura_pkg.sv
// Shared widths, FSM state codes and reset-value helper for the temperature threshold bank.
package limites_temperatura_pkg;

   localparam int NUM_LIM = 7;
   localparam int IDX_W   = 3;
   localparam int TEMP_W  = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_APPLY  = 2'd2;

   // Reset value of threshold k; wraps modulo 2^TEMP_W like the hardware adder.
   function automatic logic [TEMP_W-1:0] def_value(input logic [TEMP_W-1:0] base,
                                                   input logic [TEMP_W-1:0] step,
                                                   input int k);
      return base + step * TEMP_W'(k);
   endfunction

endpackage

// File: rtl/comparador_n.sv
// Unsigned N-bit magnitude comparator; lt is high when a < b.
module comparador_n #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);

   assign lt = (a < b);

endmodule

// File: rtl/banco_limites_temperatura.sv
// Shadow/active bank of seven temperature thresholds with ordered, atomic commit.
// Optional ascending-order verification is enabled by BANCO_LIMITES_ORDER_CHECK_EN.
module banco_limites_temperatura
   import limites_temperatura_pkg::*;
#(
   parameter logic [TEMP_W-1:0] DEF_BASE = 16'd400,
   parameter logic [TEMP_W-1:0] DEF_STEP = 16'd50
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TEMP_W-1:0] wr_data,
   input  logic              commit,
   output logic              busy,
   output logic              commit_done,
   output logic              commit_err,
   output logic [IDX_W-1:0]  err_idx,
   output logic [TEMP_W-1:0] lim_temp1,
   output logic [TEMP_W-1:0] lim_temp2,
   output logic [TEMP_W-1:0] lim_temp3,
   output logic [TEMP_W-1:0] lim_temp4,
   output logic [TEMP_W-1:0] lim_temp5,
   output logic [TEMP_W-1:0] lim_temp6,
   output logic [TEMP_W-1:0] lim_temp7
);

   logic [1:0]        state;
   logic [TEMP_W-1:0] shadow [NUM_LIM];
   logic [TEMP_W-1:0] active [NUM_LIM];
   logic              wr_fire;

   assign wr_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   // Index 7 is a legal request that simply has nowhere to land.
   assign wr_fire  = wr_valid && wr_ready && (wr_idx < IDX_W'(NUM_LIM));

   assign lim_temp1 = active[0];
   assign lim_temp2 = active[1];
   assign lim_temp3 = active[2];
   assign lim_temp4 = active[3];
   assign lim_temp5 = active[4];
   assign lim_temp6 = active[5];
   assign lim_temp7 = active[6];

`ifdef BANCO_LIMITES_ORDER_CHECK_EN
   logic [IDX_W-1:0]  pair_idx;
   logic [TEMP_W-1:0] cmp_a;
   logic [TEMP_W-1:0] cmp_b;
   logic              pair_lt;

   assign cmp_a = shadow[pair_idx];
   assign cmp_b = shadow[pair_idx + IDX_W'(1)];

   comparador_n #(.N(TEMP_W)) u_cmp (
      .a  (cmp_a),
      .b  (cmp_b),
      .lt (pair_lt)
   );
`else
   assign commit_err = 1'b0;
   assign err_idx    = '0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         commit_done <= 1'b0;
`ifdef BANCO_LIMITES_ORDER_CHECK_EN
         commit_err  <= 1'b0;
         err_idx     <= '0;
         pair_idx    <= '0;
`endif
         for (int k = 0; k < NUM_LIM; k++) begin
            shadow[k] <= def_value(DEF_BASE, DEF_STEP, k);
            active[k] <= def_value(DEF_BASE, DEF_STEP, k);
         end
      end else begin
         commit_done <= 1'b0;
`ifdef BANCO_LIMITES_ORDER_CHECK_EN
         commit_err  <= 1'b0;
`endif
         if (wr_fire) begin
            shadow[wr_idx] <= wr_data;
         end
         case (state)
            ST_IDLE: begin
               if (commit) begin
`ifdef BANCO_LIMITES_ORDER_CHECK_EN
                  state    <= ST_VERIFY;
                  pair_idx <= '0;
                  err_idx  <= '0;
`else
                  state    <= ST_APPLY;
`endif
               end
            end
`ifdef BANCO_LIMITES_ORDER_CHECK_EN
            // One adjacent pair per cycle; the last pair checked is (5,6).
            ST_VERIFY: begin
               if (!pair_lt) begin
                  err_idx    <= pair_idx;
                  commit_err <= 1'b1;
                  state      <= ST_IDLE;
               end else if (pair_idx == IDX_W'(NUM_LIM - 2)) begin
                  state <= ST_APPLY;
               end else begin
                  pair_idx <= pair_idx + IDX_W'(1);
               end
            end
`endif
            ST_APPLY: begin
               for (int k = 0; k < NUM_LIM; k++) begin
                  active[k] <= shadow[k];
               end
               commit_done <= 1'b1;
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
